// File: rtl/note_event_pkg.sv
`default_nettype none
// ============================================================================
// Package     : note_event_pkg
// Description : Shared types for the note event packer. Holds the event kind
//               and duration encodings, the packed event word layout
//               {kind[1:0], dur[1:0], tone[5:0]} and the duration-to-eighths
//               unit lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package note_event_pkg;

  typedef enum logic [1:0] {
    KIND_NOTE = 2'b00,
    KIND_REST = 2'b01,
    KIND_BAR  = 2'b10,
    KIND_RSVD = 2'b11
  } event_kind_e;

  typedef enum logic [1:0] {
    DUR_EIGHTH  = 2'd0,
    DUR_QUARTER = 2'd1,
    DUR_HALF    = 2'd2,
    DUR_WHOLE   = 2'd3
  } dur_code_e;

  typedef struct packed {
    event_kind_e kind;
    dur_code_e   dur;
    logic [5:0]  tone;
  } event_t;

  localparam int EVENT_W = $bits(event_t);

  // Length of a duration code expressed in eighth-note units.
  function automatic logic [3:0] dur_units(input dur_code_e dur);
    logic [3:0] units;
    case (dur)
      DUR_EIGHTH:  units = 4'd1;
      DUR_QUARTER: units = 4'd2;
      DUR_HALF:    units = 4'd4;
      DUR_WHOLE:   units = 4'd8;
      default:     units = 4'd0;
    endcase
    return units;
  endfunction

  function automatic event_t make_event(input event_kind_e kind,
                                        input dur_code_e   dur,
                                        input logic [5:0]  tone);
    event_t ev;
    ev.kind = kind;
    ev.dur  = dur;
    ev.tone = tone;
    return ev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : note_event_fifo
// Description : Synchronous first-word-fall-through FIFO. The head word is
//               presented combinationally from storage, so a word written
//               into an empty FIFO is visible right after the write edge.
//               A push while full is taken only when a pop frees a slot in
//               the same cycle; otherwise it is reported as dropped.
// Ports       : clk_in          - clock, rising edge
//               rst_n_in        - asynchronous active-low reset
//               push_in         - write request
//               push_data_in    - word to write
//               pop_ready_in    - consumer accepts the head word
//               head_data_out   - head word, zero when empty
//               head_valid_out  - FIFO non-empty
//               level_out       - occupancy, 0..DEPTH
//               push_drop_out   - this cycle's push was discarded (full)
// Revision    : 1.0 - initial release
// ============================================================================
module note_event_fifo
  import note_event_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = EVENT_W
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       push_in,
  input  logic [WIDTH-1:0]           push_data_in,
  input  logic                       pop_ready_in,
  output logic [WIDTH-1:0]           head_data_out,
  output logic                       head_valid_out,
  output logic [$clog2(DEPTH):0]     level_out,
  output logic                       push_drop_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  logic empty, full, pop, wr_en;

  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == FULL_LEVEL);
    pop   = !empty && pop_ready_in;
    // A full FIFO can still take a word when the head leaves this cycle.
    wr_en = push_in && (!full || pop);

    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_in;
    end
  end

  assign head_data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign head_valid_out = !empty;
  assign level_out      = level_q;
  assign push_drop_out  = push_in && full && !pop;

endmodule
`default_nettype wire

// File: rtl/note_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : note_event_packer
// Description : Converts note/rest duration flags into packed event words,
//               tracks position within the measure and inserts a bar event
//               each time a measure completes. Events are queued in an FWFT
//               FIFO for a downstream consumer.
// Ports       : clk_in, rst_n_in        - clock / async active-low reset
//               new_note_ready          - a note finished this cycle
//               new_note_tone[5:0]      - note index
//               eighth/quarter/half/whole_note - note duration flags
//               eighth/quarter/half/whole_rest - rest duration pulses
//               event_data_out[9:0]     - head word {kind, dur, tone}
//               event_valid_out         - head word valid
//               event_ready_in          - consumer accepts head word
//               fill_level_out          - FIFO occupancy
//               overflow_out            - sticky: FIFO-full drop seen
//               malformed_out           - sticky: bad flag combination seen
//               drop_count_out[7:0]     - saturating drop/malformed count
// Revision    : 1.0 - initial release
// ============================================================================
module note_event_packer
  import note_event_pkg::*;
#(
  parameter int DEPTH           = 32,
  parameter int EIGHTHS_PER_BAR = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   new_note_ready,
  input  logic [5:0]             new_note_tone,
  input  logic                   eighth_note,
  input  logic                   quarter_note,
  input  logic                   half_note,
  input  logic                   whole_note,
  input  logic                   eighth_rest,
  input  logic                   quarter_rest,
  input  logic                   half_rest,
  input  logic                   whole_rest,
  output logic [EVENT_W-1:0]     event_data_out,
  output logic                   event_valid_out,
  input  logic                   event_ready_in,
  output logic [$clog2(DEPTH):0] fill_level_out,
  output logic                   overflow_out,
  output logic                   malformed_out,
  output logic [7:0]             drop_count_out
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_BAR_PEND = 1'b1;
  localparam logic [4:0] BAR_UNITS   = 5'(EIGHTHS_PER_BAR);

  // --------------------------------------------------------------------------
  // Input classification
  // --------------------------------------------------------------------------
  logic [2:0] note_cnt, rest_cnt;
  logic       in_malformed, in_valid;
  dur_code_e  note_dur, rest_dur;
  event_t     in_event;

  always_comb begin
    note_cnt = {2'b00, eighth_note} + {2'b00, quarter_note}
             + {2'b00, half_note}   + {2'b00, whole_note};
    rest_cnt = {2'b00, eighth_rest} + {2'b00, quarter_rest}
             + {2'b00, half_rest}   + {2'b00, whole_rest};

    // Note flags are only meaningful when new_note_ready qualifies them.
    in_malformed = (new_note_ready && (note_cnt != 3'd1))
                || (rest_cnt > 3'd1)
                || (new_note_ready && (rest_cnt != 3'd0));
    in_valid = !in_malformed && (new_note_ready || (rest_cnt == 3'd1));

    if (whole_note)        note_dur = DUR_WHOLE;
    else if (half_note)    note_dur = DUR_HALF;
    else if (quarter_note) note_dur = DUR_QUARTER;
    else                   note_dur = DUR_EIGHTH;

    if (whole_rest)        rest_dur = DUR_WHOLE;
    else if (half_rest)    rest_dur = DUR_HALF;
    else if (quarter_rest) rest_dur = DUR_QUARTER;
    else                   rest_dur = DUR_EIGHTH;

    in_event = new_note_ready ? make_event(KIND_NOTE, note_dur, new_note_tone)
                              : make_event(KIND_REST, rest_dur, 6'd0);
  end

  // --------------------------------------------------------------------------
  // Capture slot plus one-entry hold register. The capture slot is written to
  // the FIFO by IDLE; while BAR_PEND owns the write port, a second arrival
  // parks in the hold register and a third is dropped.
  // --------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic       cap_valid_q, cap_valid_d;
  event_t     cap_event_q, cap_event_d;
  logic       hold_valid_q, hold_valid_d;
  event_t     hold_event_q, hold_event_d;
  logic       consume, hold_drop;

  always_comb begin
    consume      = (state_q == ST_IDLE) && cap_valid_q;
    cap_valid_d  = cap_valid_q;
    cap_event_d  = cap_event_q;
    hold_valid_d = hold_valid_q;
    hold_event_d = hold_event_q;
    hold_drop    = 1'b0;

    if (consume) begin
      cap_valid_d  = hold_valid_q;
      cap_event_d  = hold_event_q;
      hold_valid_d = 1'b0;
    end

    if (in_valid) begin
      if (!cap_valid_d) begin
        cap_valid_d = 1'b1;
        cap_event_d = in_event;
      end else if (!hold_valid_d) begin
        hold_valid_d = 1'b1;
        hold_event_d = in_event;
      end else begin
        hold_drop = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Measure accounting, applied when the captured event is written. The bar
  // is committed here, so a bar later lost to a full FIFO still advances the
  // measure number.
  // --------------------------------------------------------------------------
  logic [3:0] acc_q, acc_d;
  logic [5:0] meas_q, meas_d;
  logic [4:0] acc_sum;
  logic       bar_due;

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, dur_units(cap_event_q.dur)};
    bar_due = (acc_sum >= BAR_UNITS);
    acc_d   = acc_q;
    meas_d  = meas_q;
    if (consume) begin
      if (bar_due) begin
        acc_d  = 4'(acc_sum - BAR_UNITS);
        meas_d = meas_q + 6'd1;
      end else begin
        acc_d  = acc_sum[3:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (consume && bar_due) state_d = ST_BAR_PEND;
      ST_BAR_PEND: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  logic   push;
  event_t push_event;

  always_comb begin
    push       = 1'b0;
    push_event = cap_event_q;
    case (state_q)
      ST_IDLE: begin
        push       = cap_valid_q;
        push_event = cap_event_q;
      end
      ST_BAR_PEND: begin
        // meas_q already holds the number of the measure just completed.
        push       = 1'b1;
        push_event = make_event(KIND_BAR, DUR_EIGHTH, meas_q);
      end
      default: begin
        push       = 1'b0;
        push_event = cap_event_q;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Event storage
  // --------------------------------------------------------------------------
  logic fifo_drop;

  note_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .push_in        (push),
    .push_data_in   (push_event),
    .pop_ready_in   (event_ready_in),
    .head_data_out  (event_data_out),
    .head_valid_out (event_valid_out),
    .level_out      (fill_level_out),
    .push_drop_out  (fifo_drop)
  );

  // --------------------------------------------------------------------------
  // Error flags and saturating drop counter. A malformed input and a FIFO
  // drop can land in the same cycle, so the increment is up to two.
  // --------------------------------------------------------------------------
  logic       overflow_q, overflow_d;
  logic       malformed_q, malformed_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic [1:0] drop_incr;
  logic [8:0] drop_sum;

  always_comb begin
    overflow_d   = overflow_q | fifo_drop;
    malformed_d  = malformed_q | in_malformed;
    drop_incr    = {1'b0, in_malformed} + {1'b0, hold_drop} + {1'b0, fifo_drop};
    drop_sum     = {1'b0, drop_count_q} + {7'd0, drop_incr};
    drop_count_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cap_valid_q  <= 1'b0;
      cap_event_q  <= '0;
      hold_valid_q <= 1'b0;
      hold_event_q <= '0;
      acc_q        <= '0;
      meas_q       <= '0;
      overflow_q   <= 1'b0;
      malformed_q  <= 1'b0;
      drop_count_q <= '0;
    end else begin
      cap_valid_q  <= cap_valid_d;
      cap_event_q  <= cap_event_d;
      hold_valid_q <= hold_valid_d;
      hold_event_q <= hold_event_d;
      acc_q        <= acc_d;
      meas_q       <= meas_d;
      overflow_q   <= overflow_d;
      malformed_q  <= malformed_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow_out   = overflow_q;
  assign malformed_out  = malformed_q;
  assign drop_count_out = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_note_event_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_event_packer
// Description : Directed self-checking bench for note_event_packer. A table
//               of single-event vectors is applied from reset, followed by
//               hand-written sequences for bar insertion, accumulator carry,
//               FIFO overflow and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_event_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nn_ready = 1'b0;
  logic [5:0] nn_tone = '0;
  logic [3:0] nflags = '0;  // {whole, half, quarter, eighth}
  logic [3:0] rflags = '0;  // {whole, half, quarter, eighth}
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [5:0] fill;
  logic       ovf, malf;
  logic [7:0] drops;

  int n_cmp = 0;
  int n_err = 0;

  note_event_packer #(.DEPTH(32), .EIGHTHS_PER_BAR(8)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .new_note_ready  (nn_ready),
    .new_note_tone   (nn_tone),
    .eighth_note     (nflags[0]),
    .quarter_note    (nflags[1]),
    .half_note       (nflags[2]),
    .whole_note      (nflags[3]),
    .eighth_rest     (rflags[0]),
    .quarter_rest    (rflags[1]),
    .half_rest       (rflags[2]),
    .whole_rest      (rflags[3]),
    .event_data_out  (ev_data),
    .event_valid_out (ev_valid),
    .event_ready_in  (ev_ready),
    .fill_level_out  (fill),
    .overflow_out    (ovf),
    .malformed_out   (malf),
    .drop_count_out  (drops)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; nn_ready = 1'b0; nflags = '0; rflags = '0; ev_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Present one input cycle, then clear the inputs.
  task automatic drive(input logic rdy, input logic [5:0] tone,
                       input logic [3:0] nf, input logic [3:0] rf);
    nn_ready = rdy; nn_tone = tone; nflags = nf; rflags = rf;
    tick();
    nn_ready = 1'b0; nn_tone = '0; nflags = '0; rflags = '0;
  endtask

  // Wait (bounded) for a head word, compare it, then pop it.
  task automatic pop_expect(input string name, input logic [9:0] exp);
    int w = 0;
    while (!ev_valid && w < 20) begin
      tick();
      w++;
    end
    if (!ev_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: timeout, valid=0, expected word 0x%0h", name, exp);
    end else begin
      check(name, {22'd0, ev_data}, {22'd0, exp});
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic       rdy;
    logic [5:0] tone;
    logic [3:0] nf;
    logic [3:0] rf;
    int         exp_level;
    logic [9:0] exp_head;
    logic       exp_malf;
  } vec_t;

  vec_t vecs[12];
  logic [9:0] exp_q[$];

  initial begin
    //             rdy   tone   nf       rf       lvl head     malf
    vecs[0]  = '{1'b1, 6'd10, 4'b0010, 4'b0000, 1, 10'h04A, 1'b0};
    vecs[1]  = '{1'b1, 6'd63, 4'b0001, 4'b0000, 1, 10'h03F, 1'b0};
    vecs[2]  = '{1'b1, 6'd5,  4'b0100, 4'b0000, 1, 10'h085, 1'b0};
    vecs[3]  = '{1'b1, 6'd42, 4'b1000, 4'b0000, 2, 10'h0EA, 1'b0}; // whole -> bar
    vecs[4]  = '{1'b0, 6'd9,  4'b0000, 4'b0010, 1, 10'h140, 1'b0};
    vecs[5]  = '{1'b0, 6'd0,  4'b0000, 4'b1000, 2, 10'h1C0, 1'b0}; // whole -> bar
    vecs[6]  = '{1'b0, 6'd0,  4'b0000, 4'b0001, 1, 10'h100, 1'b0};
    vecs[7]  = '{1'b1, 6'd3,  4'b1100, 4'b0000, 0, 10'h000, 1'b1};
    vecs[8]  = '{1'b1, 6'd3,  4'b0000, 4'b0000, 0, 10'h000, 1'b1};
    vecs[9]  = '{1'b0, 6'd0,  4'b0000, 4'b0011, 0, 10'h000, 1'b1};
    vecs[10] = '{1'b1, 6'd7,  4'b0010, 4'b0001, 0, 10'h000, 1'b1};
    vecs[11] = '{1'b0, 6'd7,  4'b0100, 4'b0000, 0, 10'h000, 1'b0}; // unqualified

    // ---------------- reset state ----------------
    do_reset();
    check("reset_valid", {31'd0, ev_valid}, 32'd0);
    check("reset_data", {22'd0, ev_data}, 32'd0);
    check("reset_level", {26'd0, fill}, 32'd0);
    check("reset_flags", {30'd0, ovf, malf}, 32'd0);
    check("reset_drops", {24'd0, drops}, 32'd0);

    // ---------------- single quarter note latency ----------------
    drive(1'b1, 6'd10, 4'b0010, 4'b0000);
    check("lat_valid_c1", {31'd0, ev_valid}, 32'd0);
    tick();
    check("lat_valid_c2", {31'd0, ev_valid}, 32'd1);
    check("lat_level", {26'd0, fill}, 32'd1);
    check("lat_word", {22'd0, ev_data}, 32'h04A);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive(vecs[i].rdy, vecs[i].tone, vecs[i].nf, vecs[i].rf);
      tick();
      tick();
      check($sformatf("vec%0d_level", i), {26'd0, fill}, 32'(vecs[i].exp_level));
      check($sformatf("vec%0d_valid", i), {31'd0, ev_valid}, {31'd0, vecs[i].exp_level != 0});
      check($sformatf("vec%0d_head", i), {22'd0, ev_data}, {22'd0, vecs[i].exp_head});
      check($sformatf("vec%0d_malf", i), {31'd0, malf}, {31'd0, vecs[i].exp_malf});
      check($sformatf("vec%0d_drops", i), {24'd0, drops}, {31'd0, vecs[i].exp_malf});
    end

    // ---------------- four quarters -> bar, accumulator back to 0 ----------
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 6'd10, 4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) pop_expect("bar1_note", 10'h04A);
    pop_expect("bar1_bar", 10'h201);
    for (int i = 0; i < 3; i++) drive(1'b1, 6'd10, 4'b0010, 4'b0000);
    tick(); tick(); tick();
    check("acc0_no_bar_level", {26'd0, fill}, 32'd3);
    for (int i = 0; i < 3; i++) pop_expect("acc0_note", 10'h04A);
    drive(1'b1, 6'd10, 4'b0010, 4'b0000);
    pop_expect("acc0_note4", 10'h04A);
    pop_expect("acc0_bar2", 10'h202);

    // ---------------- whole rest at accumulator 7 ----------------
    do_reset();
    drive(1'b1, 6'd0, 4'b0001, 4'b0000);  // eighth  -> 1
    drive(1'b1, 6'd0, 4'b0010, 4'b0000);  // quarter -> 3
    drive(1'b1, 6'd0, 4'b0100, 4'b0000);  // half    -> 7
    drive(1'b0, 6'd0, 4'b0000, 4'b1000);  // whole rest -> 15: bar, acc 7
    pop_expect("acc7_e", 10'h000);
    pop_expect("acc7_q", 10'h040);
    pop_expect("acc7_h", 10'h080);
    pop_expect("acc7_rest", 10'h1C0);
    pop_expect("acc7_bar", 10'h201);
    drive(1'b1, 6'd0, 4'b0001, 4'b0000);  // 7 + 1 -> bar right away
    pop_expect("acc7_e2", 10'h000);
    pop_expect("acc7_bar2", 10'h202);

    // ---------------- overflow with 33 eighth notes ----------------
    do_reset();
    exp_q.delete();
    begin
      int units = 0;
      int meas = 0;
      for (int i = 0; i < 33; i++) begin
        exp_q.push_back({2'b00, 2'b00, 6'(i)});
        units++;
        if (units == 8) begin
          units = 0;
          meas++;
          exp_q.push_back({2'b10, 2'b00, 6'(meas)});
        end
        drive(1'b1, 6'(i), 4'b0001, 4'b0000);
        tick();
      end
    end
    tick(); tick(); tick();
    check("ovf_level", {26'd0, fill}, 32'd32);
    check("ovf_flag", {31'd0, ovf}, 32'd1);
    check("ovf_drops", {24'd0, drops}, 32'(exp_q.size() - 32));
    check("ovf_malf", {31'd0, malf}, 32'd0);
    for (int i = 0; i < 32; i++) pop_expect($sformatf("drain%0d", i), exp_q[i]);
    check("drain_empty_level", {26'd0, fill}, 32'd0);
    check("drain_empty_valid", {31'd0, ev_valid}, 32'd0);
    // 33 eighths leave acc=1 and measure 4 even though bar 4 was dropped.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 6'd20, 4'b0001, 4'b0000);
      tick();
    end
    for (int i = 0; i < 7; i++) pop_expect("post_ovf_note", 10'h014);
    pop_expect("post_ovf_bar5", 10'h205);

    // ---------------- reset mid-operation ----------------
    do_reset();
    drive(1'b1, 6'd10, 4'b0001, 4'b0000);
    for (int i = 0; i < 4; i++) drive(1'b1, 6'd10, 4'b0010, 4'b0000);
    tick();  // fifth word written, bar pending now
    check("midrst_level_before", {26'd0, fill}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, ev_valid}, 32'd0);
    check("midrst_level", {26'd0, fill}, 32'd0);
    check("midrst_data", {22'd0, ev_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("midrst_after_valid", {31'd0, ev_valid}, 32'd0);
    check("midrst_after_level", {26'd0, fill}, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 6'd10, 4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) pop_expect("midrst_note", 10'h04A);
    pop_expect("midrst_bar1", 10'h201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
